// File: rtl/mux_reply_pkg.sv
// Shared constants, FSM encoding and sub-code lookup for the reply-path arbiter.
package mux_reply_pkg;

  localparam int unsigned NCH = 4;

  localparam logic [7:0] RSP_HDR     = 8'h04;
  localparam logic [7:0] SUB_SI_READ = 8'h01;
  localparam logic [7:0] SUB_RATE    = 8'h09;
  localparam logic [7:0] SUB_RATEOUT = 8'h0A;
  localparam logic [7:0] SUB_TEM_STA = 8'hF1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
    ST_GAP
  } state_t;

  function automatic logic [7:0] sub_code(input logic [1:0] ch);
    case (ch)
      2'd0:    sub_code = SUB_SI_READ;
      2'd1:    sub_code = SUB_RATE;
      2'd2:    sub_code = SUB_RATEOUT;
      default: sub_code = SUB_TEM_STA;
    endcase
  endfunction

endpackage

// File: rtl/mux_reply_fifo.sv
// Per-channel reply buffer: staging register, {last,data} RAM, admission/drop
// control, complete-packet counter and sticky truncation flag.
module mux_reply_fifo #(
  parameter int unsigned AW = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       en,
  input  logic       rd,
  output logic [7:0] head_data,
  output logic       head_last,
  output logic       pending,
  output logic       ovf
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);
  localparam logic [AW:0] TWO_W   = (AW+1)'(2);

  logic [8:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, pkt_cnt;
  logic [AW:0] used, free_slots;
  logic        stg_valid, drop;
  logic [7:0]  stg_data;
  logic        wr_last, wr_ok, wr_en, refuse, pkt_in, pkt_out;

  // One slot is always held back for the terminator, so a packet can never
  // be left unterminated in the RAM even when its body is truncated.
  always_comb begin
    used       = wr_ptr - rd_ptr;
    free_slots = DEPTH_W - used;
    wr_last    = !en;
    wr_ok      = wr_last ? (free_slots >= ONE_W) : (!drop && (free_slots >= TWO_W));
    wr_en      = stg_valid && wr_ok;
    refuse     = stg_valid && !wr_last && !wr_ok;
    pkt_in     = wr_en && wr_last;
    pkt_out    = rd && head_last;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {wr_last, stg_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid <= 1'b0;
      stg_data  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_cnt   <= '0;
      drop      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      stg_valid <= en;
      stg_data  <= din;
      if (wr_en) wr_ptr <= wr_ptr + ONE_W;
      if (rd)    rd_ptr <= rd_ptr + ONE_W;
      if (stg_valid) begin
        if (wr_last)     drop <= 1'b0;
        else if (!wr_ok) drop <= 1'b1;
      end
      if (refuse) ovf <= 1'b1;
      case ({pkt_in, pkt_out})
        2'b10:   pkt_cnt <= pkt_cnt + ONE_W;
        2'b01:   pkt_cnt <= pkt_cnt - ONE_W;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  assign {head_last, head_data} = mem[rd_ptr[AW-1:0]];
  assign pending = (pkt_cnt != '0);

endmodule

// File: rtl/mux_reply_arbiter.sv
// Collects per-channel reply bursts and serializes complete packets onto the
// host byte stream as 0x04, sub-code, payload frames with round-robin grant.
module mux_reply_arbiter
  import mux_reply_pkg::*;
#(
  parameter int unsigned AW = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] si_read_rsp_din,
  input  logic       si_read_rsp_en,
  input  logic [7:0] rate_rsp_din,
  input  logic       rate_rsp_en,
  input  logic [7:0] rateout_rsp_din,
  input  logic       rateout_rsp_en,
  input  logic [7:0] rd_tem_sta_rsp_din,
  input  logic       rd_tem_sta_rsp_en,
  output logic [7:0] rsp_dout,
  output logic       rsp_dout_en,
  output logic [3:0] ovf
);

  logic [7:0]     ch_din  [NCH];
  logic [7:0]     ch_head [NCH];
  logic [NCH-1:0] ch_en, ch_rd, ch_last, ch_pend, ch_ovf;

  assign ch_din[0] = si_read_rsp_din;
  assign ch_din[1] = rate_rsp_din;
  assign ch_din[2] = rateout_rsp_din;
  assign ch_din[3] = rd_tem_sta_rsp_din;
  assign ch_en     = {rd_tem_sta_rsp_en, rateout_rsp_en, rate_rsp_en, si_read_rsp_en};
  assign ovf       = ch_ovf;

  for (genvar g = 0; g < NCH; g++) begin : g_fifo
    mux_reply_fifo #(.AW(AW)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .din       (ch_din[g]),
      .en        (ch_en[g]),
      .rd        (ch_rd[g]),
      .head_data (ch_head[g]),
      .head_last (ch_last[g]),
      .pending   (ch_pend[g]),
      .ovf       (ch_ovf[g])
    );
  end

  state_t     state, state_n;
  logic [1:0] grant, grant_n, last_grant, last_grant_n, cand, pick;
  logic       found, out_last, out_last_n, en_n;
  logic [7:0] dout_n;

  // Output registers are loaded with the byte belonging to the next state, so
  // the state register and the visible output byte always line up.
  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    dout_n       = '0;
    en_n         = 1'b0;
    out_last_n   = 1'b0;
    ch_rd        = '0;
    found        = 1'b0;
    pick         = '0;
    cand         = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = last_grant + 2'(i);
      if (!found && ch_pend[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    case (state)
      ST_IDLE: begin
        if (found) begin
          grant_n      = pick;
          last_grant_n = pick;
          state_n      = ST_HDR0;
          dout_n       = RSP_HDR;
          en_n         = 1'b1;
        end
      end
      ST_HDR0: begin
        state_n = ST_HDR1;
        dout_n  = sub_code(grant);
        en_n    = 1'b1;
      end
      ST_HDR1: begin
        state_n      = ST_PAYLOAD;
        dout_n       = ch_head[grant];
        out_last_n   = ch_last[grant];
        en_n         = 1'b1;
        ch_rd[grant] = 1'b1;
      end
      ST_PAYLOAD: begin
        if (out_last) begin
          state_n = ST_GAP;
        end else begin
          dout_n       = ch_head[grant];
          out_last_n   = ch_last[grant];
          en_n         = 1'b1;
          ch_rd[grant] = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      last_grant  <= 2'd3;
      out_last    <= 1'b0;
      rsp_dout    <= '0;
      rsp_dout_en <= 1'b0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      last_grant  <= last_grant_n;
      out_last    <= out_last_n;
      rsp_dout    <= dout_n;
      rsp_dout_en <= en_n;
    end
  end

endmodule

// File: tb/tb_mux_reply_arbiter.sv
// Directed self-checking bench for mux_reply_arbiter: framing, latency,
// truncation, back-to-back packets, mid-frame reset and round-robin order.
module tb_mux_reply_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00, d3 = 8'h00;
  logic       e0 = 1'b0, e1 = 1'b0, e2 = 1'b0, e3 = 1'b0;
  logic [7:0] rsp_dout;
  logic       rsp_dout_en;
  logic [3:0] ovf;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;

  logic [7:0]  obytes[$];
  int unsigned ocyc[$];

  logic [7:0] subs [4] = '{8'h01, 8'h09, 8'h0A, 8'hF1};

  mux_reply_arbiter #(.AW(6)) dut (
    .clk                (clk),
    .rst                (rst),
    .si_read_rsp_din    (d0),
    .si_read_rsp_en     (e0),
    .rate_rsp_din       (d1),
    .rate_rsp_en        (e1),
    .rateout_rsp_din    (d2),
    .rateout_rsp_en     (e2),
    .rd_tem_sta_rsp_din (d3),
    .rd_tem_sta_rsp_en  (e3),
    .rsp_dout           (rsp_dout),
    .rsp_dout_en        (rsp_dout_en),
    .ovf                (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rsp_dout_en === 1'b1) begin
      obytes.push_back(rsp_dout);
      ocyc.push_back(cyc);
    end
  end

  task automatic drive(input logic [3:0] e, input logic [7:0] a, b, c, d);
    {e3, e2, e1, e0} = e;
    d0 = a; d1 = b; d2 = c; d3 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    obytes.delete();
    ocyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++; if (rsp_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", rsp_dout); end
    checks++; if (rsp_dout_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", rsp_dout_en); end
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL reset_ovf got=%b exp=0000", ovf); end
    rst = 1'b0;
    obytes.delete(); ocyc.delete();
    idle(8);
    checks++; if (obytes.size() != 0) begin errors++; $display("FAIL reset_quiet got=%0d bytes exp=0", obytes.size()); end
  endtask

  task automatic test_single();
    logic [7:0] exp[$];
    int unsigned c;
    obytes.delete(); ocyc.delete();
    drive(4'b0010, 8'h00, 8'hA1, 8'h00, 8'h00);
    drive(4'b0010, 8'h00, 8'hB2, 8'h00, 8'h00);
    c = cyc;
    drive(4'b0010, 8'h00, 8'hC3, 8'h00, 8'h00);
    idle(20);
    exp = '{8'h04, 8'h09, 8'hA1, 8'hB2, 8'hC3};
    checks++; if (obytes.size() != exp.size()) begin errors++; $display("FAIL single_len got=%0d exp=%0d", obytes.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < obytes.size(); i++) begin
      checks++;
      if (obytes[i] !== exp[i] || ocyc[i] != c + 3 + i) begin
        errors++; $display("FAIL single_byte%0d got=%h@%0d exp=%h@%0d", i, obytes[i], ocyc[i], exp[i], c + 3 + i);
      end
    end
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL single_ovf got=%b exp=0000", ovf); end
  endtask

  task automatic test_dual();
    logic [7:0] exp[$];
    int unsigned expc[$];
    int unsigned c;
    apply_reset();
    c = cyc;
    drive(4'b1001, 8'h11, 8'h00, 8'h00, 8'h22);
    idle(25);
    exp  = '{8'h04, 8'h01, 8'h11, 8'h04, 8'hF1, 8'h22};
    expc = '{c + 3, c + 4, c + 5, c + 8, c + 9, c + 10};
    checks++; if (obytes.size() != exp.size()) begin errors++; $display("FAIL dual_len got=%0d exp=%0d", obytes.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < obytes.size(); i++) begin
      checks++;
      if (obytes[i] !== exp[i] || ocyc[i] != expc[i]) begin
        errors++; $display("FAIL dual_byte%0d got=%h@%0d exp=%h@%0d", i, obytes[i], ocyc[i], exp[i], expc[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    int unsigned expc[$];
    int unsigned c0;
    obytes.delete(); ocyc.delete();
    c0 = cyc;
    drive(4'b0001, 8'h01, 8'h00, 8'h00, 8'h00);
    drive(4'b0001, 8'h02, 8'h00, 8'h00, 8'h00);
    idle(1);
    drive(4'b0001, 8'h03, 8'h00, 8'h00, 8'h00);
    idle(25);
    exp  = '{8'h04, 8'h01, 8'h01, 8'h02, 8'h04, 8'h01, 8'h03};
    expc = '{c0 + 4, c0 + 5, c0 + 6, c0 + 7, c0 + 10, c0 + 11, c0 + 12};
    checks++; if (obytes.size() != exp.size()) begin errors++; $display("FAIL b2b_len got=%0d exp=%0d", obytes.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < obytes.size(); i++) begin
      checks++;
      if (obytes[i] !== exp[i] || ocyc[i] != expc[i]) begin
        errors++; $display("FAIL b2b_byte%0d got=%h@%0d exp=%h@%0d", i, obytes[i], ocyc[i], exp[i], expc[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp[$];
    int unsigned c;
    int unsigned bad;
    obytes.delete(); ocyc.delete();
    c = 0;
    for (int i = 1; i <= 70; i++) begin
      c = cyc;
      drive(4'b0100, 8'h00, 8'h00, 8'(i), 8'h00);
    end
    idle(160);
    exp = '{8'h04, 8'h0A};
    for (int i = 1; i <= 63; i++) exp.push_back(8'(i));
    exp.push_back(8'd70);
    checks++; if (obytes.size() != exp.size()) begin errors++; $display("FAIL ovf_len got=%0d exp=%0d", obytes.size(), exp.size()); end
    bad = 0;
    for (int i = 0; i < exp.size() && i < obytes.size(); i++) begin
      if (obytes[i] !== exp[i] || ocyc[i] != c + 3 + i) begin
        bad++;
        if (bad == 1) $display("FAIL ovf_byte%0d got=%h@%0d exp=%h@%0d", i, obytes[i], ocyc[i], exp[i], c + 3 + i);
      end
    end
    checks++; if (bad != 0) errors++;
    checks++; if (ovf !== 4'b0100) begin errors++; $display("FAIL ovf_flag got=%b exp=0100", ovf); end
  endtask

  task automatic test_midframe_reset();
    logic [7:0] exp[$];
    int unsigned c;
    obytes.delete(); ocyc.delete();
    c = 0;
    for (int i = 1; i <= 10; i++) begin
      c = cyc;
      drive(4'b0010, 8'h00, 8'(i), 8'h00, 8'h00);
    end
    idle(6);
    checks++; if (cyc != c + 7 || rsp_dout_en !== 1'b1 || rsp_dout !== 8'h03) begin
      errors++; $display("FAIL mid_payload got=%b/%h@%0d exp=1/03@%0d", rsp_dout_en, rsp_dout, cyc, c + 7);
    end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checks++; if (rsp_dout_en !== 1'b0 || rsp_dout !== 8'h00) begin
      errors++; $display("FAIL mid_reset_out got=%b/%h exp=0/00", rsp_dout_en, rsp_dout);
    end
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL mid_reset_ovf got=%b exp=0000", ovf); end
    obytes.delete(); ocyc.delete();
    idle(20);
    checks++; if (obytes.size() != 0) begin errors++; $display("FAIL mid_no_resume got=%0d bytes exp=0", obytes.size()); end
    c = cyc;
    drive(4'b1000, 8'h00, 8'h00, 8'h00, 8'h5A);
    idle(15);
    exp = '{8'h04, 8'hF1, 8'h5A};
    checks++; if (obytes.size() != exp.size()) begin errors++; $display("FAIL mid_fresh_len got=%0d exp=%0d", obytes.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < obytes.size(); i++) begin
      checks++;
      if (obytes[i] !== exp[i] || ocyc[i] != c + 3 + i) begin
        errors++; $display("FAIL mid_fresh_byte%0d got=%h@%0d exp=%h@%0d", i, obytes[i], ocyc[i], exp[i], c + 3 + i);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp[$];
    logic [7:0] v [4];
    apply_reset();
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 2; b++) begin
        for (int ch = 0; ch < 4; ch++) v[ch] = 8'((ch + 1) * 16 + p * 2 + b);
        drive(4'b1111, v[0], v[1], v[2], v[3]);
      end
      idle(1);
    end
    idle(100);
    for (int p = 0; p < 3; p++) begin
      for (int ch = 0; ch < 4; ch++) begin
        exp.push_back(8'h04);
        exp.push_back(subs[ch]);
        exp.push_back(8'((ch + 1) * 16 + p * 2));
        exp.push_back(8'((ch + 1) * 16 + p * 2 + 1));
      end
    end
    checks++; if (obytes.size() != exp.size()) begin errors++; $display("FAIL rr_len got=%0d exp=%0d", obytes.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < obytes.size(); i++) begin
      checks++;
      if (obytes[i] !== exp[i]) begin
        errors++; $display("FAIL rr_byte%0d got=%h exp=%h", i, obytes[i], exp[i]);
      end
    end
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL rr_ovf got=%b exp=0000", ovf); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_back_to_back();
    test_overflow();
    test_midframe_reset();
    test_round_robin();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_reply_arbiter.md
# mux_reply_arbiter

Return-path companion to the command demultiplexer. It collects reply byte bursts from the four read-class responders (SI read, input rate, output rate, temperature/status) and buffers each burst per channel. It then serializes complete bursts onto the single host-bound byte stream, framed with the same two-byte header the host uses for read commands (0x04, sub-code). Sources are fully decoupled: they may burst simultaneously.

## Interface
- AW, 6: per-channel FIFO address width; depth 2^AW bytes.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- si_read_rsp_din / _en  in  8 / 1  SI-read reply burst, channel 0, sub-code 0x01.
- rate_rsp_din / _en  in  8 / 1  input-rate reply, channel 1, sub-code 0x09.
- rateout_rsp_din / _en  in  8 / 1  output-rate reply, channel 2, sub-code 0x0A.
- rd_tem_sta_rsp_din / _en  in  8 / 1  temperature/status reply, channel 3, sub-code 0xF1.
- rsp_dout  out  8  framed reply byte.
- rsp_dout_en  out  1  high for every valid byte of a frame, contiguous within a frame.
- ovf  out  4  sticky per-channel truncation flag, bit n = channel n.

## Operation
- Packet = one maximal run of consecutive _en-high cycles; 1-byte packets are legal.
- Write path, per channel:
  - Each accepted byte goes into a 1-byte staging register.
  - On the next cycle it is written to the FIFO as {last, data}, with last = !_en in that cycle.
- FIFO admission:
  - A byte with last=0 is written only if free slots ≥ 2.
  - A byte with last=1 is written if free slots ≥ 1.
- Truncation: once a last=0 byte is refused, the channel enters drop mode and ovf[n] is set.
  - In drop mode, further last=0 bytes are discarded.
  - The terminating byte is still written with last=1, so every stored packet is terminated.
  - Drop mode clears at packet end.
- pkt_cnt[n] (width AW+1):
  - +1 when a last=1 byte is written.
  - −1 when a last=1 byte is read.
  - Unchanged if both occur in the same cycle.
- Read-side FSM states: IDLE, HDR0, HDR1, PAYLOAD, GAP.
  - IDLE: if any pkt_cnt ≠ 0, grant by round-robin starting at (last_grant+1) mod 4, then go to HDR0. Otherwise stay in IDLE.
  - HDR0: emit 0x04, then HDR1.
  - HDR1: emit the granted sub-code, then PAYLOAD.
  - PAYLOAD: emit one FIFO byte per cycle. After emitting the last=1 byte, go to GAP.
  - GAP: rsp_dout_en=0 for one cycle, then IDLE.
- last_grant updates on grant; its reset value is 3, so channel 0 has first priority.
- FIFO read is combinational from head. No backpressure: the downstream consumer accepts every byte.
- Writes and the read of the same channel proceed concurrently. Write traffic never stalls the read FSM.

## Timing
- Reset values: rsp_dout=0, rsp_dout_en=0, ovf=0, all FIFOs empty, pkt_cnt=0, staging invalid, drop mode off, state IDLE, last_grant=3.
- All outputs are registered.
- Reference latency: the last source byte is in cycle c and _en is low in c+1, with the arbiter idle and no competing packet.
  - Terminating write at the end of c+1.
  - Grant in c+2.
  - 0x04 on the output in c+3, sub-code in c+4.
  - L payload bytes in c+5 … c+4+L.
  - rsp_dout_en low in c+5+L.
- Frames are separated by ≥1 idle cycle. Frame length is always L+2.
- A new packet on a channel that is currently being read is not granted until the current frame reaches IDLE.
- Reset mid-frame: output returns to 0/0 in the cycle after rst is sampled. No partial frame resumes.
- Equal-cycle burst start on all four channels gives frames in order 0, 1, 2, 3. After that order, the next winner is channel 0 again.

## Structure
- Shared package mux_reply_pkg holds:
  - RSP_HDR = 8'h04.
  - The sub-code constants SUB_SI_READ = 8'h01, SUB_RATE = 8'h09, SUB_RATEOUT = 8'h0A, SUB_TEM_STA = 8'hF1.
  - The channel count NCH = 4.
  - The FSM state encoding.
- Sub-module mux_reply_fifo is instantiated four times. It contains:
  - the staging register;
  - a 9-bit × 2^AW distributed RAM;
  - the admission/drop logic;
  - pkt_cnt;
  - ovf.
- The arbiter and FSM live in the top module.

## Test plan
- Channel 1 burst A1 B2 C3 → output 04 09 A1 B2 C3 in c+3…c+7, then en=0; ovf=0.
- Channels 0 and 3 each send 1 byte (11 and 22) in the same cycle → 04 01 11, gap, 04 F1 22.
- Channel 2 sends 70 bytes with AW=6:
  - Frame carries bytes 1–63 plus byte 70, total 64 payload bytes.
  - ovf=4'b0100.
  - pkt_cnt returns to 0.
- Channel 0 sends two back-to-back bursts (01 02; one idle cycle; 03) → two frames 04 01 01 02 and 04 01 03.
- rst asserted during the payload of a 10-byte frame → next cycle rsp_dout_en=0. A fresh 1-byte packet then frames normally.
- All four channels busy continuously for 3 rounds → grant order 0,1,2,3 repeating, with no channel granted twice in a row while others have pending packets.
